// File: rtl/flag_cond_unit.sv
// Flag/condition unit: latches the add/sub flags into a PSW, evaluates branch condition
// codes against it over a valid/ready handshake, and keeps a small PSW save/restore stack.
module flag_cond_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flags_we,
    input  logic       cf_in,
    input  logic       ovf_in,
    input  logic       sf_in,
    input  logic       zf_in,
    output logic [3:0] psw,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       taken_valid,
    output logic       taken,
    input  logic       taken_ready,
    input  logic       push,
    input  logic       pop,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err,
    input  logic       err_clr
);

    logic [3:0]     psw_q, psw_d;
    logic           tv_q, tv_d;
    logic           tk_q, tk_d;
    logic           err_q, err_d;
    logic [PTR_W:0] sp_q, sp_d;
    logic [PTR_W:0] sp_m1;
    logic [3:0]     stack_q [STACK_DEPTH];
    logic           accept, push_ok, pop_ok, err_set;

    // PSW layout is {cf, ovf, sf, zf}; unsigned codes use the borrow convention.
    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] p);
        logic c, v, s, z;
        {c, v, s, z} = p;
        case (code)
            4'd0:    cond_eval = z;
            4'd1:    cond_eval = !z;
            4'd2:    cond_eval = c;
            4'd3:    cond_eval = !c;
            4'd4:    cond_eval = s;
            4'd5:    cond_eval = !s;
            4'd6:    cond_eval = v;
            4'd7:    cond_eval = !v;
            4'd8:    cond_eval = !c && !z;
            4'd9:    cond_eval = c || z;
            4'd10:   cond_eval = (s == v);
            4'd11:   cond_eval = (s != v);
            4'd12:   cond_eval = !z && (s == v);
            4'd13:   cond_eval = z || (s != v);
            4'd14:   cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign stack_full  = (sp_q == (PTR_W+1)'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign sp_m1       = sp_q - 1'b1;

    assign cond_ready = !tv_q || taken_ready;
    assign accept     = cond_valid && cond_ready;

    assign push_ok = push && !pop && !stack_full;
    assign pop_ok  = pop && !push && !stack_empty;
    assign err_set = (push && pop) || (push && stack_full) || (pop && stack_empty);

    always_comb begin
        psw_d = psw_q;
        sp_d  = sp_q;
        tv_d  = tv_q;
        tk_d  = tk_q;
        err_d = err_q;
        // A restore from the stack overrides a coincident flag load.
        if (pop_ok) begin
            psw_d = stack_q[sp_m1[PTR_W-1:0]];
            sp_d  = sp_m1;
        end else if (flags_we) begin
            psw_d = {cf_in, ovf_in, sf_in, zf_in};
        end
        if (push_ok) begin
            sp_d = sp_q + 1'b1;
        end
        if (accept) begin
            tv_d = 1'b1;
            tk_d = cond_eval(cond_code, psw_q);
        end else if (taken_ready) begin
            tv_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psw_q <= '0;
            sp_q  <= '0;
            tv_q  <= 1'b0;
            tk_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            psw_q <= psw_d;
            sp_q  <= sp_d;
            tv_q  <= tv_d;
            tk_q  <= tk_d;
            err_q <= err_d;
        end
    end

    // Entry storage is not reset; the pointer alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_q[sp_q[PTR_W-1:0]] <= psw_q;
        end
    end

    assign psw         = psw_q;
    assign taken_valid = tv_q;
    assign taken       = tk_q;
    assign stack_err   = err_q;

endmodule
